// File: rtl/mcycle_ctrl.sv
// mcycle_ctrl -- multicycle control sequencer for the 32-bit MIPS-style core.
//
// A Moore FSM that walks the shared ALU, the shared instruction/data memory
// port and the register file through fetch, decode, execute, memory and
// writeback cycles. Every datapath select and write enable is decoded from the
// current state. The exceptions are pcen, which also uses the ALU zero flag,
// and the FETCH strobes, which are gated by memready.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-high; forces FETCH
//   op/funct  instruction register fields (decoded in DECODE, MEMADR, IEX)
//   zero      ALU zero flag (BEQ)
//   memready  memory access completes this cycle
//   pcen, irwrite, iord, memwrite, regwrite, regdst, memtoreg,
//   alusrca, alusrcb, aluop, pcsrc   datapath controls
//   state     current state (debug)
//   illegal   trap flag
//
// Configuration macro: ILLEGAL_TRAP_EN
//   defined   -> TRAP is absorbing until reset
//   undefined -> TRAP lasts one cycle and the instruction retires as a NOP
module mcycle_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       pcen,
  output logic       irwrite,
  output logic       iord,
  output logic       memwrite,
  output logic       regwrite,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic [3:0] state,
  output logic       illegal
);

  // WIDTH exists only so that every datapath block instantiates the same way.
  if (WIDTH < 1) begin : g_bad_width
    $error("mcycle_ctrl: WIDTH must be positive");
  end

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b000001;
  localparam logic [5:0] OP_SW   = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b000011;
  localparam logic [5:0] OP_SUBI = 6'b000100;
  localparam logic [5:0] OP_BEQ  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000111;
  localparam logic [5:0] OP_JAL  = 6'b001000;
  localparam logic [5:0] FN_JR   = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REX    = 4'd6,
    S_ALUWB  = 4'd7,
    S_IEX    = 4'd8,
    S_IWB    = 4'd9,
    S_BEQ    = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13,
    S_TRAP   = 4'd14
  } state_t;

  state_t state_q, state_d;
  logic   pcwrite, branch;

  // State register. Reset is asynchronous, so the Moore decode below shows
  // FETCH controls as soon as reset rises. This also aborts any instruction
  // that is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = memready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:     state_d = S_MEMADR;
          OP_R:             state_d = (funct == FN_JR) ? S_JR : S_REX;
          OP_ADDI, OP_SUBI: state_d = S_IEX;
          OP_BEQ:           state_d = S_BEQ;
          OP_J:             state_d = S_JUMP;
          OP_JAL:           state_d = S_JAL;
          default:          state_d = S_TRAP;
        endcase
      end
      // Only LW and SW reach MEMADR, so bit 0 of the opcode tells them apart.
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = memready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = memready ? S_FETCH : S_MEMWR;
      S_REX:    state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_IEX:    state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_JAL:    state_d = S_FETCH;
      S_JR:     state_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:   state_d = S_TRAP;
`else
      S_TRAP:   state_d = S_FETCH;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  // Output decode. The controls are taken straight from state_q and are not
  // registered a second time. irwrite and pcen must follow memready and zero
  // in the same cycle, and they must show FETCH as soon as reset asserts.
  always_comb begin
    irwrite  = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    regdst   = 2'b00;
    memtoreg = 2'b00;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    aluop    = 2'b00;
    pcsrc    = 2'b00;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = memready;
        pcwrite = memready;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD:  iord = 1'b1;
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 2'b01;
      end
      // The write stays asserted while the memory stalls. The memory commits
      // it on the edge where memready is high.
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_REX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 2'b01;
      end
      S_IEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = (op == OP_SUBI) ? 2'b01 : 2'b00;
      end
      S_IWB:    regwrite = 1'b1;
      S_BEQ: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      // $31 is written from the PC, which FETCH has already advanced by 4.
      S_JAL: begin
        pcsrc    = 2'b10;
        pcwrite  = 1'b1;
        regwrite = 1'b1;
        regdst   = 2'b10;
        memtoreg = 2'b10;
      end
      S_JR: begin
        pcsrc   = 2'b11;
        pcwrite = 1'b1;
      end
      S_TRAP:   illegal = 1'b1;
      default: ;
    endcase
  end

  assign pcen  = pcwrite | (branch & zero);
  assign state = state_q;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Directed bench for mcycle_ctrl. Inputs are driven, and every control output
// is sampled, on the falling clock edge. Each check compares the full control
// vector against hand-written constants.
module tb_mcycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, memready;
  logic       pcen, irwrite, iord, memwrite, regwrite, alusrca, illegal;
  logic [1:0] regdst, memtoreg, alusrcb, aluop, pcsrc;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mcycle_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memready(memready), .pcen(pcen), .irwrite(irwrite), .iord(iord),
    .memwrite(memwrite), .regwrite(regwrite), .regdst(regdst),
    .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .pcsrc(pcsrc), .state(state), .illegal(illegal)
  );

  // Expected vector layout:
  //   {state, pcen, irwrite, iord, memwrite, regwrite, regdst, memtoreg,
  //    alusrca, alusrcb, aluop, pcsrc, illegal}
  task automatic expect_out(input string tag, input logic [3:0] st,
                            input logic pe, input logic ir, input logic io,
                            input logic mw, input logic rw,
                            input logic [1:0] rd, input logic [1:0] mt,
                            input logic sa, input logic [1:0] sb,
                            input logic [1:0] ao, input logic [1:0] ps,
                            input logic il);
    logic [20:0] got, exp;
    got = {state, pcen, irwrite, iord, memwrite, regwrite, regdst, memtoreg,
           alusrca, alusrcb, aluop, pcsrc, illegal};
    exp = {st, pe, ir, io, mw, rw, rd, mt, sa, sb, ao, ps, il};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // FETCH: alusrcb=01, and irwrite and pcen both follow memready.
  task automatic expect_fetch(input string tag, input logic mr);
    expect_out(tag, 4'd0, mr, mr, 0, 0, 0, 2'b00, 2'b00, 0, 2'b01, 2'b00, 2'b00, 0);
  endtask

  task automatic expect_decode(input string tag);
    expect_out(tag, 4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 2'b00, 2'b00, 0);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0; memready = 1'b0;
    tick();
    expect_fetch("reset_mr0", 1'b0);
    memready = 1'b1; #1;
    expect_fetch("reset_mr1", 1'b1);

    // LW: 0,1,2,3,4,0
    op = 6'b000001;
    reset = 1'b0;
    tick(); expect_decode("lw_decode");
    tick(); expect_out("lw_memadr", 4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 2'b00, 2'b00, 0);
    tick(); expect_out("lw_memrd", 4'd3, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0);
    tick(); expect_out("lw_memwb", 4'd4, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0, 2'b00, 2'b00, 2'b00, 0);
    tick(); expect_fetch("lw_done", 1'b1);

    // SW with memready low for the first two MEMWR cycles
    op = 6'b000010;
    tick(); expect_decode("sw_decode");
    tick(); expect_out("sw_memadr", 4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 2'b00, 2'b00, 0);
    memready = 1'b0;
    tick(); expect_out("sw_memwr1", 4'd5, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0);
    tick(); expect_out("sw_memwr2", 4'd5, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0);
    memready = 1'b1; #1;
    expect_out("sw_memwr3", 4'd5, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0);
    tick(); expect_fetch("sw_done", 1'b1);

    // FETCH stall
    memready = 1'b0;
    tick(); expect_fetch("fetch_stall", 1'b0);
    memready = 1'b1;

    // BEQ taken; pcen also follows zero within the same cycle
    op = 6'b000101; zero = 1'b1;
    tick(); expect_decode("beq_t_decode");
    tick(); expect_out("beq_taken", 4'd10, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 2'b01, 2'b01, 0);
    zero = 1'b0; #1;
    expect_out("beq_zero_drop", 4'd10, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 2'b01, 2'b01, 0);
    zero = 1'b1;
    tick(); expect_fetch("beq_t_done", 1'b1);
    // BEQ not taken
    zero = 1'b0;
    tick(); expect_decode("beq_n_decode");
    tick(); expect_out("beq_not_taken", 4'd10, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 2'b01, 2'b01, 0);
    tick(); expect_fetch("beq_n_done", 1'b1);

    // J
    op = 6'b000111;
    tick(); expect_decode("j_decode");
    tick(); expect_out("j_jump", 4'd11, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b10, 0);
    tick(); expect_fetch("j_done", 1'b1);

    // JAL
    op = 6'b001000;
    tick(); expect_decode("jal_decode");
    tick(); expect_out("jal", 4'd12, 1, 0, 0, 0, 1, 2'b10, 2'b10, 0, 2'b00, 2'b00, 2'b10, 0);
    tick(); expect_fetch("jal_done", 1'b1);

    // JR
    op = 6'b000000; funct = 6'b001000;
    tick(); expect_decode("jr_decode");
    tick(); expect_out("jr", 4'd13, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b11, 0);
    tick(); expect_fetch("jr_done", 1'b1);

    // R-type (funct=add)
    funct = 6'b100000;
    tick(); expect_decode("r_decode");
    tick(); expect_out("r_rex", 4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 2'b10, 2'b00, 0);
    tick(); expect_out("r_aluwb", 4'd7, 0, 0, 0, 0, 1, 2'b01, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0);
    tick(); expect_fetch("r_done", 1'b1);

    // ADDI then SUBI
    op = 6'b000011;
    tick(); expect_decode("addi_decode");
    tick(); expect_out("addi_iex", 4'd8, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 2'b00, 2'b00, 0);
    tick(); expect_out("addi_iwb", 4'd9, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0);
    tick(); expect_fetch("addi_done", 1'b1);
    op = 6'b000100;
    tick(); expect_decode("subi_decode");
    tick(); expect_out("subi_iex", 4'd8, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 2'b01, 2'b00, 0);
    tick(); expect_out("subi_iwb", 4'd9, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0);
    tick(); expect_fetch("subi_done", 1'b1);

    // Reset in the middle of an LW aborts it immediately
    op = 6'b000001;
    tick(); tick(); tick();
    expect_out("abort_memrd", 4'd3, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0);
    reset = 1'b1; #1;
    expect_fetch("abort_reset", 1'b1);
    tick(); reset = 1'b0;
    expect_fetch("abort_release", 1'b1);

    // Illegal opcode
    op = 6'b101010;
    tick(); expect_decode("ill_decode");
    tick(); expect_out("ill_trap", 4'd14, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 1);
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 20; i++) begin
      tick();
      expect_out("ill_hold", 4'd14, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 1);
    end
    reset = 1'b1; #1;
    expect_fetch("ill_reset", 1'b1);
    tick(); reset = 1'b0;
`else
    tick(); expect_fetch("ill_done", 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcycle_ctrl.md
# mcycle_ctrl

Multicycle control sequencer for the 32-bit MIPS-style core: replaces the single-cycle main decoder with a Moore state machine that steps one shared ALU, one shared instruction/data memory port and the register file through fetch, decode, execute, memory and writeback cycles. It sits between the instruction register (op/funct), the datapath flags (zero) and the memory port (memready), and drives every datapath mux select and write enable.

## Interface
- WIDTH, 32, datapath width. The controller does not use it internally; it exists for uniform instantiation.
- clk  in  1  clock; all state updates occur on the rising edge.
- reset  in  1  asynchronous, active-high; forces state to FETCH.
- op  in  6  opcode from the instruction register.
- funct  in  6  function field from the instruction register.
- zero  in  1  ALU zero flag.
- memready  in  1  memory access complete this cycle.
- pcen  out  1  PC register enable; equals pcwrite | (branch & zero).
- irwrite  out  1  instruction register load.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memwrite  out  1  memory write strobe.
- regwrite  out  1  register file write.
- regdst  out  2  write register select: 00 = rt, 01 = rd, 10 = $31.
- memtoreg  out  2  write data select: 00 = ALUOut, 01 = memory data, 10 = PC.
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A.
- alusrcb  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = signimm, 11 = signimm<<2.
- aluop  out  2  ALU operation: 00 = add, 01 = sub, 10 = decode by funct.
- pcsrc  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = register A.
- state  out  4  current state, for debug.
- illegal  out  1  trap flag.

## Operation
- Opcodes: R = 000000, LW = 000001, SW = 000010, ADDI = 000011, SUBI = 000100, BEQ = 000101, J = 000111, JAL = 001000. JR is R-type with funct = 001000.
- Outputs are a Moore decode of state. The exceptions are pcen (which also uses zero) and the memready-gated strobes. Every output not listed for a state is 0.
- State encoding, with outputs and next-state transition:
  - FETCH(0): alusrcb=01, irwrite=pcwrite=memready. Stays in FETCH while !memready; otherwise → DECODE.
  - DECODE(1): alusrcb=11. Branches on op: LW/SW → MEMADR; R with funct=001000 → JR; other R → REX; ADDI/SUBI → IEX; BEQ → BEQ; J → JUMP; JAL → JAL; any other op → TRAP.
  - MEMADR(2): alusrca=1, alusrcb=10 → MEMRD if LW, MEMWR if SW.
  - MEMRD(3): iord=1. Holds while !memready; otherwise → MEMWB.
  - MEMWB(4): regwrite=1, memtoreg=01 → FETCH.
  - MEMWR(5): iord=1, memwrite=1. Holds while !memready; otherwise → FETCH.
  - REX(6): alusrca=1, aluop=10 → ALUWB.
  - ALUWB(7): regwrite=1, regdst=01 → FETCH.
  - IEX(8): alusrca=1, alusrcb=10. aluop=00 for ADDI, 01 for SUBI → IWB.
  - IWB(9): regwrite=1 → FETCH.
  - BEQ(10): alusrca=1, aluop=01, pcsrc=01, branch internal=1 → FETCH.
  - JUMP(11): pcsrc=10, pcwrite=1 → FETCH.
  - JAL(12): pcsrc=10, pcwrite=1, regwrite=1, regdst=10, memtoreg=10 → FETCH. $31 receives the already-incremented PC.
  - JR(13): pcsrc=11, pcwrite=1 → FETCH.
  - TRAP(14): illegal=1. Behaviour depends on configuration (see Configuration).
- Unused encodings 15 and above → FETCH on the next edge.
- op and funct are sampled combinationally. They are only decoded in DECODE, MEMADR and IEX, where the instruction register is stable.

## Timing
- Reset: state=FETCH. Outputs: alusrcb=01, irwrite=pcen=memready, all other outputs 0.
- Reset asserted mid-instruction aborts it immediately. Every enable combinationally reflects FETCH from the moment reset asserts.
- Cycles per instruction, with memready held high:
  - LW: 5
  - SW, R, ADDI, SUBI: 4
  - BEQ, J, JAL, JR: 3
- Each cycle with memready low adds one cycle in FETCH, MEMRD or MEMWR.
- memwrite is held high for every cycle spent in MEMWR. The memory must treat the write as committed on the edge where memready=1.
- BEQ:
  - zero=1 → pcen=1 for exactly one cycle.
  - zero=0 → pcen=0.

## Configuration
- ILLEGAL_TRAP_EN defined: TRAP is absorbing. It holds illegal=1 and all write enables 0 until reset.
- ILLEGAL_TRAP_EN undefined: TRAP asserts illegal=1 for one cycle, then → FETCH. The instruction executes as a 3-cycle NOP.

## Test plan
- Reset, then LW (op=000001) with memready=1 → state sequence 0,1,2,3,4,0. MEMWB has regwrite=1, memtoreg=01.
- SW with memready low for 2 cycles in MEMWR → memwrite=1 for 3 cycles, then FETCH. regwrite is never asserted.
- BEQ twice, once with zero=1 and once with zero=0 → pcen=1 in BEQ only when zero=1; pcsrc=01, aluop=01.
- JAL (op=001000) → in state 12: pcen=1, regwrite=1, regdst=10, memtoreg=10, pcsrc=10. JR (op=000000, funct=001000) → state 13 with pcsrc=11.
- ADDI then SUBI → IEX aluop=00 then 01. Each instruction takes 4 cycles.
- Illegal op=101010:
  - With ILLEGAL_TRAP_EN: illegal stays 1 and state stays 14 for 20 cycles; reset returns state to 0.
  - Without it: illegal pulses for 1 cycle, then state=0.
